// File: rtl/mdu_pkg.sv
// Shared opcode encodings, FSM states and latencies for the multiply/divide unit.
// MDU_MADD_EN enables the MADD/MADDU/MSUB/MSUBU accumulate opcodes.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } mdu_state_e;

  localparam int CNT_W   = 4;
  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;

  // Opcodes that occupy the multiplier path; accumulate ops only exist when enabled.
  function automatic logic is_mul_op(input mdu_op_e op);
    logic r;
    r = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: r = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: r = 1'b1;
`endif
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_div_op(input mdu_op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath: 64-bit product and quotient/remainder from the
// latched operands; signedness follows the latched opcode.
module mdu_calc
  import mdu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  mdu_op_e     op,
  output logic [63:0] prod,
  output logic [31:0] quot,
  output logic [31:0] rem,
  output logic        div_zero
);

  logic        sgn;
  logic        a_neg;
  logic        b_neg;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] b_safe;
  logic [31:0] q_mag;
  logic [31:0] r_mag;

  assign sgn   = is_signed_op(op);
  assign a_neg = sgn & a[31];
  assign b_neg = sgn & b[31];

  // Two's-complement extension keeps the low 64 bits of the product exact for both signednesses.
  assign a_ext = {{32{a_neg}}, a};
  assign b_ext = {{32{b_neg}}, b};
  assign prod  = a_ext * b_ext;

  // Divide magnitudes, then restore signs: quotient truncates toward zero,
  // remainder follows the dividend. 0x80000000 negates to itself, which is
  // the correct unsigned magnitude.
  assign a_mag    = a_neg ? (32'd0 - a) : a;
  assign b_mag    = b_neg ? (32'd0 - b) : b;
  assign div_zero = (b == 32'd0);
  assign b_safe   = div_zero ? 32'd1 : b_mag;
  assign q_mag    = a_mag / b_safe;
  assign r_mag    = a_mag % b_safe;
  assign quot     = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem      = a_neg ? (32'd0 - r_mag) : r_mag;

endmodule

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit with HI/LO registers, fixed-latency FSM.
// Define MDU_MADD_EN to add the MADD/MADDU/MSUB/MSUBU accumulate opcodes.
module mdu
  import mdu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] srcA,
  input  logic [31:0] srcB,
  input  logic [3:0]  MDUOp,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, a_d;
  logic [31:0]      b_q, b_d;
  mdu_op_e          op_q, op_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic             done_q, done_d;

  mdu_op_e     op_in;
  logic [63:0] prod;
  logic [63:0] mul_res;
  logic [31:0] quot;
  logic [31:0] rem;
  logic        div_zero;

  assign op_in = mdu_op_e'(MDUOp);

  mdu_calc u_calc (
    .a        (a_q),
    .b        (b_q),
    .op       (op_q),
    .prod     (prod),
    .quot     (quot),
    .rem      (rem),
    .div_zero (div_zero)
  );

`ifdef MDU_MADD_EN
  // Accumulate against HI/LO as they stand at the commit edge.
  always_comb begin
    mul_res = prod;
    case (op_q)
      OP_MADD, OP_MADDU: mul_res = {hi_q, lo_q} + prod;
      OP_MSUB, OP_MSUBU: mul_res = {hi_q, lo_q} - prod;
      default:           mul_res = prod;
    endcase
  end
`else
  assign mul_res = prod;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (is_mul_op(op_in)) begin
            a_d     = srcA;
            b_d     = srcB;
            op_d    = op_in;
            cnt_d   = CNT_W'(MUL_LAT);
            state_d = S_MUL;
          end else if (is_div_op(op_in)) begin
            a_d     = srcA;
            b_d     = srcB;
            op_d    = op_in;
            cnt_d   = CNT_W'(DIV_LAT);
            state_d = S_DIV;
          end else if (op_in == OP_MTHI) begin
            hi_d = srcA;
          end else if (op_in == OP_MTLO) begin
            lo_d = srcA;
          end
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          if (state_q == S_MUL) begin
            {hi_d, lo_d} = mul_res;
          end else if (!div_zero) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= OP_NONE;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule
